// File: rtl/btn_pulse_sched.sv
// Two-button press scheduler: debounces each raw input and latches clean presses as pending requests.
// Requests are served one at a time on a single-cycle pulse channel, using round-robin and a lockout gap.
module btn_pulse_sched #(
  parameter int SYNC_STAGES = 3,
  parameter int LOCKOUT     = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_200H,
  input  logic             rst,
  input  logic             inp_0,
  input  logic             inp_1,
  output logic             pulse_out,
  output logic             pulse_src,
  output logic             busy,
  output logic [1:0]       pend,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  localparam int LCW = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [LCW-1:0]   lock_reg, lock_next;
  logic [1:0]       inp_raw;
  logic [1:0]       stable_reg, stable_next;
  logic [1:0]       press_evt;
  logic [1:0]       pend_reg, pend_next;
  logic [1:0]       grant_clr;
  logic             gnt;
  logic             rr_reg, rr_next;
  logic             src_reg, src_next;
  logic             pulse_reg, busy_reg;
  logic [CNT_W-1:0] cnt0_reg, cnt0_next;
  logic [CNT_W-1:0] cnt1_reg, cnt1_next;

  assign inp_raw = {inp_1, inp_0};

  // Stable flag only moves when the whole window agrees; mixed windows hold it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      logic [SYNC_STAGES-1:0] sr_reg;

      always_ff @(posedge clk_200H or posedge rst) begin
        if (rst) sr_reg <= '0;
        else     sr_reg <= {sr_reg[SYNC_STAGES-2:0], inp_raw[gi]};
      end

      assign stable_next[gi] = (&sr_reg)  ? 1'b1 :
                               (~|sr_reg) ? 1'b0 : stable_reg[gi];
    end
  endgenerate

  assign press_evt = stable_next & ~stable_reg;
  // A press on the grant edge survives the clear.
  assign pend_next = (pend_reg & ~grant_clr) | press_evt;

  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    grant_clr  = 2'b00;
    gnt        = 1'b0;
    rr_next    = rr_reg;
    src_next   = src_reg;
    cnt0_next  = cnt0_reg;
    cnt1_next  = cnt1_reg;
    case (state_reg)
      S_IDLE: begin
        if (pend_reg != 2'b00) begin
          gnt       = (pend_reg == 2'b11) ? rr_reg : pend_reg[1];
          grant_clr = gnt ? 2'b10 : 2'b01;
          if (gnt) cnt1_next = cnt1_reg + CNT_W'(1);
          else     cnt0_next = cnt0_reg + CNT_W'(1);
          src_next   = gnt;
          rr_next    = ~gnt;
          state_next = S_FIRE;
        end
      end
      S_FIRE: begin
        if (LOCKOUT == 0) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_LOCK;
          lock_next  = LCW'(LOCKOUT - 1);
        end
      end
      S_LOCK: begin
        if (lock_reg == '0) state_next = S_IDLE;
        else                lock_next  = lock_reg - LCW'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_200H or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      lock_reg   <= '0;
      stable_reg <= 2'b00;
      pend_reg   <= 2'b00;
      rr_reg     <= 1'b0;
      src_reg    <= 1'b0;
      cnt0_reg   <= '0;
      cnt1_reg   <= '0;
      pulse_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lock_reg   <= lock_next;
      stable_reg <= stable_next;
      pend_reg   <= pend_next;
      rr_reg     <= rr_next;
      src_reg    <= src_next;
      cnt0_reg   <= cnt0_next;
      cnt1_reg   <= cnt1_next;
      // Outputs come straight from flops so downstream sees no decode glitches.
      pulse_reg  <= (state_next == S_FIRE);
      busy_reg   <= (state_next != S_IDLE);
    end
  end

  assign pulse_out = pulse_reg;
  assign pulse_src = src_reg;
  assign busy      = busy_reg;
  assign pend      = pend_reg;
  assign cnt_0     = cnt0_reg;
  assign cnt_1     = cnt1_reg;

endmodule

// File: tb/tb_btn_pulse_sched.sv
// Directed bench for btn_pulse_sched: main instance at LOCKOUT=4, a second at LOCKOUT=12
// for pend-merge and grant-edge retention (needs a LOCK window longer than two debounce periods).
`timescale 1us/1ns
module tb_btn_pulse_sched;

  logic       clk_200H = 1'b0;
  logic       rst = 1'b1;
  logic       inp_0 = 1'b0, inp_1 = 1'b0;
  logic       pulse_out, pulse_src, busy;
  logic [1:0] pend;
  logic [7:0] cnt_0, cnt_1;

  logic       in_l0 = 1'b0, in_l1 = 1'b0;
  logic       pulse_out_l, pulse_src_l, busy_l;
  logic [1:0] pend_l;
  logic [7:0] cnt_0_l, cnt_1_l;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cnt_l = 0;
  logic src_q[$];
  int   cyc_q[$];

  btn_pulse_sched #(.SYNC_STAGES(3), .LOCKOUT(4), .CNT_W(8)) u_dut (
    .clk_200H(clk_200H), .rst(rst), .inp_0(inp_0), .inp_1(inp_1),
    .pulse_out(pulse_out), .pulse_src(pulse_src), .busy(busy),
    .pend(pend), .cnt_0(cnt_0), .cnt_1(cnt_1)
  );

  btn_pulse_sched #(.SYNC_STAGES(3), .LOCKOUT(12), .CNT_W(8)) u_dut_long (
    .clk_200H(clk_200H), .rst(rst), .inp_0(in_l0), .inp_1(in_l1),
    .pulse_out(pulse_out_l), .pulse_src(pulse_src_l), .busy(busy_l),
    .pend(pend_l), .cnt_0(cnt_0_l), .cnt_1(cnt_1_l)
  );

  // 200 Hz clock
  always #2500 clk_200H = ~clk_200H;

  always @(posedge clk_200H) cyc <= cyc + 1;

  always @(negedge clk_200H) begin
    if (pulse_out) begin
      pulse_cnt <= pulse_cnt + 1;
      src_q.push_back(pulse_src);
      cyc_q.push_back(cyc);
    end
    if (pulse_out_l) pulse_cnt_l <= pulse_cnt_l + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_200H);
    #1;
  endtask

  task automatic press_both_and_check(input string tag);
    int base;
    logic s0, s1;
    int gap;
    base = src_q.size();
    inp_0 = 1'b1; inp_1 = 1'b1;
    tick(20);
    check_eq({tag, "_npulses"}, src_q.size() - base, 2);
    s0 = 1'b1; s1 = 1'b0; gap = -1;
    if (src_q.size() >= base + 2) begin
      s0  = src_q[base];
      s1  = src_q[base + 1];
      gap = cyc_q[base + 1] - cyc_q[base];
    end
    check_eq({tag, "_src_first"}, s0, 0);
    check_eq({tag, "_src_second"}, s1, 1);
    check_eq({tag, "_spacing"}, gap, 6);
    inp_0 = 1'b0; inp_1 = 1'b0;
    tick(10);
  endtask

  task automatic run_long_pattern(input string tag, input logic [39:0] pat,
                                  input int chk_a, input logic [1:0] pend_a,
                                  input int chk_b, input logic [1:0] pend_b);
    for (int i = 0; i < 40; i++) begin
      in_l0 = pat[i];
      tick(1);
      if (i == 3)     check_eq({tag, "_pend_first"}, pend_l, 2'b01);
      if (i == 4)     check_eq({tag, "_pulse_first"}, pulse_out_l, 1'b1);
      if (i == chk_a) check_eq({tag, "_pend_pre_grant"}, pend_l, pend_a);
      if (i == chk_b) begin
        check_eq({tag, "_pulse_regrant"}, pulse_out_l, 1'b1);
        check_eq({tag, "_pend_post_grant"}, pend_l, pend_b);
      end
    end
  endtask

  initial begin
    int p0;
    logic [39:0] pat_a;
    logic [39:0] pat_b;

    // Reset with inputs wiggling
    for (int i = 0; i < 6; i++) begin
      inp_0 = ~inp_0; inp_1 = (i > 1);
      tick(1);
    end
    check_eq("rst_pulse_out", pulse_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pend", pend, 0);
    check_eq("rst_cnt_0", cnt_0, 0);
    check_eq("rst_cnt_1", cnt_1, 0);
    check_eq("rst_src", pulse_src, 0);
    inp_0 = 1'b0; inp_1 = 1'b0;
    rst = 1'b0;
    tick(20);
    check_eq("idle_no_pulse", pulse_cnt, 0);

    // Clean press on inp_1, sampled first at edge k
    inp_1 = 1'b1;
    tick(3);
    check_eq("p1_pend_k2", pend, 2'b00);
    tick(1);
    check_eq("p1_pend_k3", pend, 2'b10);
    check_eq("p1_nopulse_k3", pulse_out, 0);
    tick(1);
    check_eq("p1_pulse_k4", pulse_out, 1);
    check_eq("p1_src_k4", pulse_src, 1);
    check_eq("p1_cnt_1", cnt_1, 1);
    check_eq("p1_pend_k4", pend, 2'b00);
    tick(1);
    check_eq("p1_pulse_k5", pulse_out, 0);
    check_eq("p1_src_hold", pulse_src, 1);
    tick(3);
    check_eq("p1_busy_k8", busy, 1);
    tick(1);
    check_eq("p1_busy_k9", busy, 0);
    inp_1 = 1'b0;
    tick(10);
    check_eq("p1_release_pulses", pulse_cnt, 1);

    // Bounce on inp_0: sub-cycle chatter, then cycle-level chatter, then hold
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      inp_0 = ~inp_0;
      #500;
    end
    tick(1);
    for (int i = 0; i < 10; i++) begin
      inp_0 = (i == 0 || i == 2 || i == 3 || i == 5 || i == 7 || i == 8);
      tick(1);
      if (i == 9) check_eq("bnc_chatter_pend", pend, 2'b00);
    end
    inp_0 = 1'b1;
    tick(8);
    check_eq("bnc_one_pulse", pulse_cnt - p0, 1);
    check_eq("bnc_cnt_0", cnt_0, 1);
    inp_0 = 1'b0;
    tick(1);
    inp_0 = 1'b1;
    tick(10);
    check_eq("bnc_glitch_no_pulse", pulse_cnt - p0, 1);
    inp_0 = 1'b0;
    tick(10);

    // Simultaneous presses from reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    press_both_and_check("tie1");
    check_eq("tie1_cnt_0", cnt_0, 1);
    check_eq("tie1_cnt_1", cnt_1, 1);
    press_both_and_check("tie2");
    check_eq("tie2_cnt_0", cnt_0, 2);
    check_eq("tie2_cnt_1", cnt_1, 2);

    // Merge two presses inside one LOCK window (rises at k+10, k+16; regrant at k+18)
    pat_a = 40'h000000E38F;
    p0 = pulse_cnt_l;
    run_long_pattern("merge", pat_a, 17, 2'b01, 18, 2'b00);
    check_eq("merge_pulses", pulse_cnt_l - p0, 2);
    check_eq("merge_cnt_0", cnt_0_l, 2);

    // Press rising exactly on the grant edge k+18 is retained and served at k+32
    pat_b = 40'h000003838F;
    p0 = pulse_cnt_l;
    run_long_pattern("gedge", pat_b, 17, 2'b01, 18, 2'b01);
    check_eq("gedge_pulses", pulse_cnt_l - p0, 3);
    check_eq("gedge_cnt_0", cnt_0_l, 5);

    // Counter wrap
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 255; i++) begin
      inp_0 = 1'b1; tick(4);
      inp_0 = 1'b0; tick(4);
    end
    check_eq("wrap_cnt_255", cnt_0, 8'd255);
    inp_0 = 1'b1; tick(4);
    inp_0 = 1'b0; tick(4);
    check_eq("wrap_cnt_0", cnt_0, 8'd0);
    check_eq("wrap_pulses", pulse_cnt - p0, 256);

    // Reset asserted mid-FIRE: rr=1 after inp_0-only grants, so inp_1 wins and pend[0] waits
    inp_0 = 1'b1; inp_1 = 1'b1;
    tick(5);
    check_eq("abort_pulse_before", pulse_out, 1);
    check_eq("abort_src_before", pulse_src, 1);
    check_eq("abort_pend_before", pend, 2'b01);
    #1000;
    rst = 1'b1;
    #1;
    check_eq("abort_pulse_cut", pulse_out, 0);
    check_eq("abort_pend_clear", pend, 2'b00);
    check_eq("abort_busy_clear", busy, 0);
    inp_0 = 1'b0; inp_1 = 1'b0;
    tick(1);
    rst = 1'b0;
    p0 = pulse_cnt;
    tick(10);
    check_eq("abort_no_pulse_after", pulse_cnt - p0, 0);
    check_eq("abort_cnt_0", cnt_0, 0);
    check_eq("abort_cnt_1", cnt_1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
